// File: rtl/sweep_count_ctrl.sv
// Bounded up/down sweep counter: lo->hi->lo repeated 'sweeps' times, then a one-cycle done pulse.
// Latency: count is lo on the edge that accepts start; pause freezes a run, abort cancels it.
module sweep_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [3:0]       sweeps,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic [3:0]       remaining,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [WIDTH-1:0] lo_q, hi_q, lo_nx, hi_nx, count_nx;
  logic             dir_nx, busy_nx, done_nx, err_nx;
  logic [3:0]       rem_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      count     <= '0;
      dir       <= 1'b0;
      remaining <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      lo_q      <= lo_nx;
      hi_q      <= hi_nx;
      count     <= count_nx;
      dir       <= dir_nx;
      remaining <= rem_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lo_nx    = lo_q;
    hi_nx    = hi_q;
    count_nx = count;
    dir_nx   = dir;
    rem_nx   = remaining;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (sweeps != 4'd0)) begin
            lo_nx    = lo;
            hi_nx    = hi;
            count_nx = lo;
            dir_nx   = 1'b1;
            rem_nx   = sweeps;
            busy_nx  = 1'b1;
            state_nx = UP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      UP: begin
        // abort outranks pause; outputs other than busy simply hold
        if (abort) begin
          state_nx = IDLE;
        end else begin
          busy_nx = 1'b1;
          if (!pause) begin
            if (count == hi_q) begin
              dir_nx   = 1'b0;
              count_nx = count - ONE;
              state_nx = DOWN;
            end else begin
              count_nx = count + ONE;
            end
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          busy_nx = 1'b1;
          if (!pause) begin
            if (count != lo_q) begin
              count_nx = count - ONE;
            end else if (remaining == 4'd1) begin
              rem_nx   = 4'd0;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
              state_nx = DONE;
            end else begin
              // lo is visited once per turnaround, so the next sweep resumes at lo+1
              rem_nx   = remaining - 4'd1;
              dir_nx   = 1'b1;
              count_nx = lo_q + ONE;
              state_nx = UP;
            end
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/sweep_count_ctrl.md
SWEEP_COUNT_CTRL -- requirements
Module: sweep_count_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the count datapath and the bound inputs.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a sweep run, sampled only in IDLE.
REQ-005 Port: abort  input  1  synchronous cancel of a running sweep.
REQ-006 Port: pause  input  1  freeze count/state while high, in UP/DOWN only.
REQ-007 Port: lo  input  WIDTH  lower sweep bound, latched on accepted start.
REQ-008 Port: hi  input  WIDTH  upper sweep bound, latched on accepted start.
REQ-009 Port: sweeps  input  4  number of lo->hi->lo sweeps, latched on accepted start.
REQ-010 Port: count  output  WIDTH  registered up/down counter value.
REQ-011 Port: dir  output  1  1 = counting up, 0 = counting down.
REQ-012 Port: remaining  output  4  sweeps not yet completed.
REQ-013 Port: busy  output  1  high in UP or DOWN.
REQ-014 Port: done  output  1  one-cycle pulse on completion of the last sweep.
REQ-015 Port: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL have four states: IDLE, UP, DOWN, DONE; all outputs SHALL be registered.
REQ-017 IDLE, start=1, lo<hi (unsigned), sweeps!=0: latch lo/hi/sweeps; count<=lo, dir<=1, remaining<=sweeps, next state UP.
REQ-018 IDLE, start=1, lo>=hi or sweeps==0: err pulses 1 cycle; state and count unchanged; no latch.
REQ-019 UP, not paused: if count==hi_latched then dir<=0, count<=count-1, next state DOWN; else count<=count+1.
REQ-020 DOWN, not paused, count!=lo_latched: count<=count-1.
REQ-021 DOWN, not paused, count==lo_latched, remaining==1: remaining<=0, count holds lo, next state DONE.
REQ-022 DOWN, not paused, count==lo_latched, remaining>1: remaining<=remaining-1, dir<=1, count<=lo+1, next state UP.
REQ-023 DONE: done=1 for exactly that cycle, busy=0, count holds; next state IDLE unconditionally.
REQ-024 Cycle budget per accepted run: 2*(hi-lo)*sweeps + 1 non-paused busy-state edges from accept to DONE entry.
REQ-025 Count SHALL never leave [lo_latched, hi_latched] during a run; no wrap-around is possible.
REQ-026 pause=1 in UP/DOWN: count, dir, remaining, state frozen; busy stays 1; pause ignored in IDLE/DONE.
REQ-027 abort=1 in UP/DOWN: next state IDLE, count/dir/remaining hold, busy<=0, no done, no err.
REQ-028 abort and pause together: abort wins.
REQ-029 start while busy or in DONE: ignored, no err.
REQ-030 Changes on lo/hi/sweeps during a run SHALL have no effect.

Reset
REQ-031 rst low SHALL immediately force state IDLE, count=0, dir=0, remaining=0, busy=0, done=0, err=0, latched bounds=0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse; operation resumes on first edge after rst high, from IDLE.

Verification
REQ-033 lo=2, hi=5, sweeps=1, start one cycle -> count 2,3,4,5,4,3,2 on successive edges, then done=1 one cycle, count stays 2, busy low.
REQ-034 lo=0, hi=3, sweeps=2 -> count 0,1,2,3,2,1,0,1,2,3,2,1,0; remaining 2->1 at first return to 0; single done pulse at the end.
REQ-035 start with lo=6, hi=6 and again with sweeps=0 -> err pulses each time, count/state unchanged, busy stays 0.
REQ-036 lo=1, hi=9, sweeps=1; pause high 3 cycles at count=4 -> count holds 4 for 3 cycles, then resumes 5; total run length +3 cycles.
REQ-037 abort at count=7 during UP with pause also high -> IDLE next cycle, count=7, busy=0, no done; new start accepted afterwards.
REQ-038 rst low at count=5 in DOWN -> count=0, busy=0 asynchronously, no done; after release start with lo=0, hi=1, sweeps=1 runs 0,1,0 then done.
